// File: rtl/zanagotchi_nucleo.sv
// ---------------------------------------------------------------------------
// zanagotchi_nucleo
//   Pet core. It holds an activity state machine and N_ATTR saturating
//   attribute counters. A prescaler produces one attribute update ("tick")
//   every TICK_DIV clock cycles. During an update the attribute of the
//   current activity gains GAIN and every other attribute loses DECAY.
//   When the active attribute reaches full, the pet leaves the activity on
//   its own. The pet dies when one attribute is empty (MORTE_MODO=0) or when
//   all attributes are empty (MORTE_MODO=1). MORTO is absorbing until reset.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   M_IDLE   | no activity; every attribute decays on tick (estado = 0)
//   M_ACT    | activity act_code-1 running; its attribute gains on tick
//            | (estado = act_code)
//   M_MORTO  | dead; commands ignored, attributes frozen (estado = N_ATTR+1)
//
// Ports
//   clk        game clock; all state changes on its rising edge
//   rst_n      asynchronous, active-low reset
//   btn_code   0 = no press, k+1 = request activity k (already debounced)
//   estado     0 = IDLE, k+1 = ACT_k, N_ATTR+1 = MORTO
//   atributos  attribute k at [k*ATTR_W +: ATTR_W]
//   morreu     high while estado == MORTO
//   tick       1-cycle pulse in the cycle whose closing edge updates attributes
//   cmd_ack    1-cycle pulse, the cycle after a command changed the state
// ---------------------------------------------------------------------------
module zanagotchi_nucleo #(
    parameter int N_ATTR     = 3,
    parameter int ATTR_W     = 8,
    parameter int ATTR_MAX   = 100,
    parameter int ATTR_INIT  = 100,
    parameter int TICK_DIV   = 100,
    parameter int GAIN       = 5,
    parameter int DECAY      = 1,
    parameter int MORTE_MODO = 0,
    parameter int CODE_W     = $clog2(N_ATTR + 1),
    parameter int ST_W       = $clog2(N_ATTR + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CODE_W-1:0]        btn_code,
    output logic [ST_W-1:0]          estado,
    output logic [N_ATTR*ATTR_W-1:0] atributos,
    output logic                     morreu,
    output logic                     tick,
    output logic                     cmd_ack
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW1   = ATTR_W + 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [AW1-1:0]    MAX_X     = AW1'(ATTR_MAX);
    localparam logic [AW1-1:0]    GAIN_X    = AW1'(GAIN);
    localparam logic [ATTR_W-1:0] MAX_V     = ATTR_W'(ATTR_MAX);
    localparam logic [ATTR_W-1:0] INIT_V    = ATTR_W'(ATTR_INIT);
    localparam logic [ATTR_W-1:0] DECAY_V   = ATTR_W'(DECAY);
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(N_ATTR);
    localparam logic [ST_W-1:0]   ST_IDLE   = '0;
    localparam logic [ST_W-1:0]   ST_MORTO  = ST_W'(N_ATTR + 1);

    // Codes above N_ATTR can only appear when the code field has spare values.
    localparam bit CODE_HAS_SPARE = ((2 ** CODE_W) - 1) > N_ATTR;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ACT,
        M_MORTO
    } modo_t;

    modo_t               modo;
    logic [CODE_W-1:0]   act_code;
    logic [CODE_W-1:0]   btn_prev;
    logic [PRE_W-1:0]    pre;
    logic [ATTR_W-1:0]   attr     [N_ATTR];
    logic [ATTR_W-1:0]   attr_upd [N_ATTR];
    logic [N_ATTR-1:0]   is_zero;
    logic [N_ATTR-1:0]   hit_max;
    logic                code_ok;
    logic                cmd;
    logic                dead_upd;
    logic                auto_exit;

    // ---------------------------------------------------------------
    // Command detect: a new nonzero, in-range code compared with last cycle.
    // ---------------------------------------------------------------
    generate
        if (CODE_HAS_SPARE) begin : g_code_range
            assign code_ok = (btn_code <= CODE_LAST);
        end else begin : g_code_full
            assign code_ok = 1'b1;
        end
    endgenerate

    assign cmd  = (btn_code != '0) && (btn_code != btn_prev) && code_ok;
    assign tick = (pre == PRE_LAST);

    // ---------------------------------------------------------------
    // Candidate attribute values for the next tick, from the current state.
    // The gain path is one bit wider so the saturation compare never wraps;
    // the decay path compares before subtracting so it never goes negative.
    // ---------------------------------------------------------------
    generate
        for (genvar k = 0; k < N_ATTR; k++) begin : g_attr
            logic [AW1-1:0]    up;
            logic [ATTR_W-1:0] dn;
            logic              sel;

            assign sel = (modo == M_ACT) && (act_code == CODE_W'(k + 1));
            assign up  = {1'b0, attr[k]} + GAIN_X;
            assign dn  = attr[k] - DECAY_V;

            assign attr_upd[k] = sel ? ((up > MAX_X) ? MAX_V : up[ATTR_W-1:0])
                                     : ((attr[k] < DECAY_V) ? '0 : dn);

            assign is_zero[k] = (attr_upd[k] == '0);
            assign hit_max[k] = sel && (attr_upd[k] == MAX_V);

            assign atributos[k*ATTR_W +: ATTR_W] = attr[k];
        end
    endgenerate

    assign dead_upd  = (MORTE_MODO != 0) ? (&is_zero) : (|is_zero);
    assign auto_exit = |hit_max;

    // ---------------------------------------------------------------
    // State, attributes and registered outputs.
    // Priority at a tick edge: death, then auto-exit, then any command.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modo     <= M_IDLE;
            act_code <= '0;
            btn_prev <= '0;
            pre      <= '0;
            estado   <= ST_IDLE;
            morreu   <= 1'b0;
            cmd_ack  <= 1'b0;
            for (int k = 0; k < N_ATTR; k++) begin
                attr[k] <= INIT_V;
            end
        end else begin
            btn_prev <= btn_code;
            pre      <= tick ? '0 : (pre + PRE_ONE);
            cmd_ack  <= 1'b0;

            if (tick && (modo != M_MORTO)) begin
                for (int k = 0; k < N_ATTR; k++) begin
                    attr[k] <= attr_upd[k];
                end
            end

            case (modo)
                M_IDLE, M_ACT: begin
                    if (tick && dead_upd) begin
                        modo   <= M_MORTO;
                        estado <= ST_MORTO;
                        morreu <= 1'b1;
                    end else if (tick && auto_exit) begin
                        modo   <= M_IDLE;
                        estado <= ST_IDLE;
                    end else if (cmd) begin
                        if (modo == M_IDLE) begin
                            modo     <= M_ACT;
                            act_code <= btn_code;
                            estado   <= ST_W'(btn_code);
                            cmd_ack  <= 1'b1;
                        end else if (btn_code == act_code) begin
                            modo    <= M_IDLE;
                            estado  <= ST_IDLE;
                            cmd_ack <= 1'b1;
                        end
                    end
                end
                default: begin
                    // MORTO holds until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zanagotchi_nucleo.sv
module tb_zanagotchi_nucleo;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int MAXV = 100;
    localparam int INIT = 100;
    localparam int TD   = 100;
    localparam int GAIN = 5;
    localparam int DEC  = 1;
    localparam int DEAD = N + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  btn;
    logic [2:0]  est0, est1;
    logic [23:0] atr0, atr1;
    logic        mor0, mor1, tk0, tk1, ack0, ack1;

    always #5 clk = ~clk;

    zanagotchi_nucleo #(.MORTE_MODO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_code(btn), .estado(est0),
        .atributos(atr0), .morreu(mor0), .tick(tk0), .cmd_ack(ack0)
    );

    zanagotchi_nucleo #(.MORTE_MODO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_code(btn), .estado(est1),
        .atributos(atr1), .morreu(mor1), .tick(tk1), .cmd_ack(ack1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 follows dut0 (any-zero death), 1 follows dut1 (all-zero death).
    int m_attr [2][N];
    int m_st   [2];
    int m_prev [2];
    int m_ack  [2];
    int m_pre;

    function automatic logic [2:0] o_st(input int i);
        return (i == 0) ? est0 : est1;
    endfunction

    function automatic logic [7:0] o_at(input int i, input int k);
        logic [23:0] v;
        v = (i == 0) ? atr0 : atr1;
        return v[k*W +: W];
    endfunction

    function automatic logic o_mor(input int i);
        return (i == 0) ? mor0 : mor1;
    endfunction

    function automatic logic o_tk(input int i);
        return (i == 0) ? tk0 : tk1;
    endfunction

    function automatic logic o_ack(input int i);
        return (i == 0) ? ack0 : ack1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) m_attr[i][k] = INIT;
            m_st[i]   = 0;
            m_prev[i] = 0;
            m_ack[i]  = 0;
        end
        m_pre = 0;
    endtask

    // One clock edge of the pet, straight from the behavioural rules.
    task automatic model_step(input int i, input int code);
        int  na [N];
        int  zeros;
        int  ns;
        bit  cmd, tk, dead, ax;
        cmd  = (code != 0) && (code != m_prev[i]) && (code <= N);
        tk   = (m_pre == TD - 1);
        ns   = m_st[i];
        dead = 0;
        ax   = 0;
        m_ack[i] = 0;
        if (m_st[i] != DEAD) begin
            if (tk) begin
                zeros = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_st[i] == k + 1) na[k] = (m_attr[i][k] + GAIN > MAXV) ? MAXV : m_attr[i][k] + GAIN;
                    else                  na[k] = (m_attr[i][k] - DEC < 0) ? 0 : m_attr[i][k] - DEC;
                    if (na[k] == 0) zeros++;
                end
                for (int k = 0; k < N; k++) m_attr[i][k] = na[k];
                dead = (i == 1) ? (zeros == N) : (zeros > 0);
                if (dead) ns = DEAD;
                else if (m_st[i] != 0 && na[m_st[i] - 1] == MAXV) begin
                    ax = 1;
                    ns = 0;
                end
            end
            if (!dead && !ax && cmd) begin
                if (m_st[i] == 0) begin
                    ns = code;
                    m_ack[i] = 1;
                end else if (m_st[i] == code) begin
                    ns = 0;
                    m_ack[i] = 1;
                end
            end
        end
        m_st[i]   = ns;
        m_prev[i] = code;
    endtask

    // Called at a negedge; drives the code, lets one rising edge pass, returns at the next negedge.
    task automatic step(input int code);
        btn = code[1:0];
        @(posedge clk);
        model_step(0, code);
        model_step(1, code);
        m_pre = (m_pre == TD - 1) ? 0 : m_pre + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            total++; if (o_st(i) !== 3'd0) begin bad++; $display("FAIL reset_estado%0d: got %0d expected 0", i, o_st(i)); end
            for (int k = 0; k < N; k++) begin
                total++; if (o_at(i, k) !== 8'(INIT)) begin bad++; $display("FAIL reset_attr%0d_%0d: got %0d expected %0d", i, k, o_at(i, k), INIT); end
            end
            total++; if (o_mor(i) !== 1'b0) begin bad++; $display("FAIL reset_morreu%0d: got %b expected 0", i, o_mor(i)); end
            total++; if (o_tk(i) !== 1'b0) begin bad++; $display("FAIL reset_tick%0d: got %b expected 0", i, o_tk(i)); end
            total++; if (o_ack(i) !== 1'b0) begin bad++; $display("FAIL reset_ack%0d: got %b expected 0", i, o_ack(i)); end
        end
    endtask

    task automatic test_idle300();
        int ticks;
        do_reset();
        ticks = 0;
        repeat (300) begin
            step(0);
            if (tk0 === 1'b1) ticks++;
        end
        total++; if (ticks != 3) begin bad++; $display("FAIL idle_ticks: got %0d expected 3", ticks); end
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL idle_estado: got %0d expected 0", est0); end
        total++; if (mor0 !== 1'b0) begin bad++; $display("FAIL idle_morreu: got %b expected 0", mor0); end
        for (int k = 0; k < N; k++) begin
            total++; if (o_at(0, k) !== 8'd97) begin bad++; $display("FAIL idle_attr%0d: got %0d expected 97", k, o_at(0, k)); end
        end
    endtask

    task automatic test_activity();
        int exp_a [N];
        exp_a = '{85, 67, 67};
        do_reset();
        repeat (3000) step(0);
        for (int k = 0; k < N; k++) begin
            total++; if (o_at(0, k) !== 8'd70) begin bad++; $display("FAIL act_pre_attr%0d: got %0d expected 70", k, o_at(0, k)); end
        end
        step(1);
        total++; if (est0 !== 3'd1) begin bad++; $display("FAIL act_enter_estado: got %0d expected 1", est0); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL act_enter_ack: got %b expected 1", ack0); end
        repeat (299) step(0);
        for (int k = 0; k < N; k++) begin
            total++; if (o_at(0, k) !== 8'(exp_a[k])) begin bad++; $display("FAIL act_attr%0d: got %0d expected %0d", k, o_at(0, k), exp_a[k]); end
        end
        step(0);
        step(1);
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL act_leave_estado: got %0d expected 0", est0); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL act_leave_ack: got %b expected 1", ack0); end
    endtask

    task automatic test_held();
        int acks;
        do_reset();
        acks = 0;
        repeat (50) begin
            step(1);
            if (ack0 === 1'b1) acks++;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL held_acks: got %0d expected 1", acks); end
        total++; if (est0 !== 3'd1) begin bad++; $display("FAIL held_estado: got %0d expected 1", est0); end
        step(2);
        total++; if (est0 !== 3'd1) begin bad++; $display("FAIL held_switch_estado: got %0d expected 1", est0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL held_switch_ack: got %b expected 0", ack0); end
        step(0);
        step(1);
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL held_exit_estado: got %0d expected 0", est0); end
        step(2);
        total++; if (est0 !== 3'd2) begin bad++; $display("FAIL held_act1_estado: got %0d expected 2", est0); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL held_act1_ack: got %b expected 1", ack0); end
    endtask

    task automatic test_autoexit();
        do_reset();
        repeat (200) step(0);
        step(3);
        total++; if (est0 !== 3'd3) begin bad++; $display("FAIL auto_enter_estado: got %0d expected 3", est0); end
        repeat (98) step(0);
        total++; if (o_at(0, 2) !== 8'd98) begin bad++; $display("FAIL auto_pre_attr2: got %0d expected 98", o_at(0, 2)); end
        step(0);
        total++; if (o_at(0, 2) !== 8'd100) begin bad++; $display("FAIL auto_attr2: got %0d expected 100", o_at(0, 2)); end
        total++; if (o_at(0, 0) !== 8'd97) begin bad++; $display("FAIL auto_attr0: got %0d expected 97", o_at(0, 0)); end
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL auto_estado: got %0d expected 0", est0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL auto_ack: got %b expected 0", ack0); end
    endtask

    task automatic test_cmd_on_tick();
        do_reset();
        repeat (99) step(0);
        step(1);
        total++; if (est0 !== 3'd1) begin bad++; $display("FAIL cot_estado: got %0d expected 1", est0); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL cot_ack: got %b expected 1", ack0); end
        total++; if (o_at(0, 0) !== 8'd99) begin bad++; $display("FAIL cot_attr0: got %0d expected 99", o_at(0, 0)); end
        repeat (99) step(0);
        step(1);
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL cot_auto_estado: got %0d expected 0", est0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL cot_auto_ack: got %b expected 0", ack0); end
        total++; if (o_at(0, 0) !== 8'd100) begin bad++; $display("FAIL cot_auto_attr0: got %0d expected 100", o_at(0, 0)); end
        total++; if (o_at(0, 1) !== 8'd98) begin bad++; $display("FAIL cot_auto_attr1: got %0d expected 98", o_at(0, 1)); end
    endtask

    task automatic test_death();
        int viol;
        do_reset();
        repeat (9999) step(0);
        total++; if (mor0 !== 1'b0) begin bad++; $display("FAIL death_early: got %b expected 0", mor0); end
        total++; if (o_at(0, 1) !== 8'd1) begin bad++; $display("FAIL death_pre_attr1: got %0d expected 1", o_at(0, 1)); end
        step(0);
        total++; if (mor0 !== 1'b1) begin bad++; $display("FAIL death_morreu: got %b expected 1", mor0); end
        total++; if (est0 !== 3'(DEAD)) begin bad++; $display("FAIL death_estado: got %0d expected %0d", est0, DEAD); end
        viol = 0;
        repeat (300) begin
            step($urandom_range(0, 3));
            if (est0 !== 3'(DEAD) || ack0 !== 1'b0 || mor0 !== 1'b1 || atr0 !== 24'd0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL death_absorb: got %0d bad cycles expected 0", viol); end
    endtask

    task automatic test_mode1_hold();
        do_reset();
        step(1);
        repeat (9998) step(1);
        total++; if (mor0 !== 1'b0) begin bad++; $display("FAIL m1_pre_morreu0: got %b expected 0", mor0); end
        step(1);
        total++; if (mor0 !== 1'b1) begin bad++; $display("FAIL m1_morreu0: got %b expected 1", mor0); end
        total++; if (mor1 !== 1'b0) begin bad++; $display("FAIL m1_alive1: got %b expected 0", mor1); end
        total++; if (o_at(1, 0) !== 8'd1) begin bad++; $display("FAIL m1_fome1: got %0d expected 1", o_at(1, 0)); end
        total++; if (est1 !== 3'd0) begin bad++; $display("FAIL m1_estado1: got %0d expected 0", est1); end
        repeat (99) step(1);
        total++; if (mor1 !== 1'b0) begin bad++; $display("FAIL m1_pre_morreu1: got %b expected 0", mor1); end
        step(1);
        total++; if (mor1 !== 1'b1) begin bad++; $display("FAIL m1_morreu1: got %b expected 1", mor1); end
        total++; if (est1 !== 3'(DEAD)) begin bad++; $display("FAIL m1_dead_estado1: got %0d expected %0d", est1, DEAD); end
        total++; if (atr1 !== 24'd0) begin bad++; $display("FAIL m1_dead_attrs1: got %h expected 0", atr1); end
    endtask

    task automatic test_random();
        int code;
        int left;
        do_reset();
        code = 0;
        left = 0;
        for (int c = 0; c < 16100; c++) begin
            if (c >= 6000) begin
                code = 0;
            end else if (left == 0) begin
                code = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 3));
                left = $urandom_range(1, 12);
            end
            if (left > 0) left--;
            step(code);
            for (int i = 0; i < 2; i++) begin
                total++; if (o_st(i) !== 3'(m_st[i])) begin bad++; $display("FAIL rnd_estado%0d c=%0d: got %0d expected %0d", i, c, o_st(i), m_st[i]); end
                for (int k = 0; k < N; k++) begin
                    total++; if (o_at(i, k) !== 8'(m_attr[i][k])) begin bad++; $display("FAIL rnd_attr%0d_%0d c=%0d: got %0d expected %0d", i, k, c, o_at(i, k), m_attr[i][k]); end
                end
                total++; if (o_mor(i) !== 1'(m_st[i] == DEAD)) begin bad++; $display("FAIL rnd_morreu%0d c=%0d: got %b expected %0d", i, c, o_mor(i), m_st[i] == DEAD); end
                total++; if (o_tk(i) !== 1'(m_pre == TD - 1)) begin bad++; $display("FAIL rnd_tick%0d c=%0d: got %b expected %0d", i, c, o_tk(i), m_pre == TD - 1); end
                total++; if (o_ack(i) !== 1'(m_ack[i])) begin bad++; $display("FAIL rnd_ack%0d c=%0d: got %b expected %0d", i, c, o_ack(i), m_ack[i]); end
            end
        end
        total++; if (mor0 !== 1'b1) begin bad++; $display("FAIL rnd_end_morreu0: got %b expected 1", mor0); end
        total++; if (mor1 !== 1'b1) begin bad++; $display("FAIL rnd_end_morreu1: got %b expected 1", mor1); end
    endtask

    task automatic test_reset_mid();
        int first;
        do_reset();
        step(2);
        repeat (56) step(2);
        total++; if (est0 !== 3'd2) begin bad++; $display("FAIL rmid_pre_estado: got %0d expected 2", est0); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (est0 !== 3'd0) begin bad++; $display("FAIL rmid_estado: got %0d expected 0", est0); end
        total++; if (atr0 !== {3{8'(INIT)}}) begin bad++; $display("FAIL rmid_attrs: got %h expected %h", atr0, {3{8'(INIT)}}); end
        total++; if (mor0 !== 1'b0 || tk0 !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL rmid_flags: got %b%b%b expected 000", mor0, tk0, ack0); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        first = 0;
        for (int c = 1; c <= 200 && first == 0; c++) begin
            step(0);
            if (tk0 === 1'b1) first = c + 1;
        end
        total++; if (first != TD) begin bad++; $display("FAIL rmid_first_tick: got %0d expected %0d", first, TD); end
        step(0);
        total++; if (o_at(0, 1) !== 8'd99) begin bad++; $display("FAIL rmid_after_tick: got %0d expected 99", o_at(0, 1)); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        test_reset();
        test_idle300();
        test_activity();
        test_held();
        test_autoexit();
        test_cmd_on_tick();
        test_death();
        test_mode1_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
